// File: rtl/sm4_key_expand_if.sv
// sm4_key_expand_if: groups the key-schedule engine's request, CK ROM and
// round-key stream signals.
//   start    : one-cycle expansion request (sampled only when idle)
//   mk       : 128-bit master key, MK0 in the top word
//   count    : CK index presented to the external registered CK ROM
//   CKi      : CK constant returned by the ROM one cycle after count
//   rk       : round key, rk_idx its index, rk_valid qualifies both
//   busy     : expansion in progress
//   done     : one-cycle pulse with the last round key (rk_idx = 31)
// slave  = engine view, master = requester / ROM / consumer view.
interface sm4_key_expand_if;
    logic         start;
    logic [127:0] mk;
    logic [4:0]   count;
    logic [31:0]  CKi;
    logic [31:0]  rk;
    logic [4:0]   rk_idx;
    logic         rk_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, mk, CKi,
        input  count, rk, rk_idx, rk_valid, busy, done
    );

    modport slave (
        input  start, mk, CKi,
        output count, rk, rk_idx, rk_valid, busy, done
    );
endinterface

// File: rtl/sm4_key_expand.sv
// sm4_sbox: GB/T 32907 SM4 S-box, 8-bit combinational lookup.
//   a_i : input byte
//   b_o : substituted byte
module sm4_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] b_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign b_o = SBOX[a_i];
endmodule

// sm4_key_expand: SM4 key schedule, one round key per clock.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of sm4_key_expand_if (start/mk request, count/CKi
//              to the registered CK ROM, rk/rk_idx/rk_valid stream, busy, done)
// PRIME spends one cycle fetching CK0 so that in RUN round i the ROM output
// already holds CK_i while count runs one index ahead.
module sm4_key_expand (
    input logic clk,
    input logic rst,
    sm4_key_expand_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    state_t      state_q, state_d;
    logic [31:0] k_q [4];
    logic [31:0] k_d [4];
    logic [4:0]  round_q, round_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] rk_q, rk_d;
    logic [4:0]  rk_idx_q, rk_idx_d;
    logic        rk_valid_q, rk_valid_d;
    logic        done_q, done_d;

    logic [31:0] x;
    logic [31:0] b;
    logic [31:0] t;
    logic [31:0] k_new;

    // Round function: tau (four parallel S-boxes) followed by L'.
    assign x = k_q[1] ^ k_q[2] ^ k_q[3] ^ bus.CKi;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_sbox (
            .a_i (x[8*g +: 8]),
            .b_o (b[8*g +: 8])
        );
    end

    assign t     = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    assign k_new = k_q[0] ^ t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            for (int unsigned j = 0; j < 4; j++) begin
                k_q[j] <= '0;
            end
            round_q    <= '0;
            count_q    <= '0;
            rk_q       <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            for (int unsigned j = 0; j < 4; j++) begin
                k_q[j] <= k_d[j];
            end
            round_q    <= round_d;
            count_q    <= count_d;
            rk_q       <= rk_d;
            rk_idx_q   <= rk_idx_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = PRIME;
            PRIME:   state_d = RUN;
            RUN:     if (round_q == 5'd31) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned j = 0; j < 4; j++) begin
            k_d[j] = k_q[j];
        end
        round_d    = round_q;
        count_d    = count_q;
        rk_d       = rk_q;
        rk_idx_d   = rk_idx_q;
        rk_valid_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (bus.start) begin
                    for (int unsigned j = 0; j < 4; j++) begin
                        k_d[j] = bus.mk[127 - 32*j -: 32] ^ FK[127 - 32*j -: 32];
                    end
                end
            end
            PRIME: begin
                count_d = 5'd1;
                round_d = '0;
            end
            RUN: begin
                // 5-bit wrap after round 31 lands on 1; IDLE clears it next cycle.
                count_d    = round_q + 5'd2;
                rk_d       = k_new;
                rk_idx_d   = round_q;
                rk_valid_d = 1'b1;
                done_d     = (round_q == 5'd31);
                k_d[0]     = k_q[1];
                k_d[1]     = k_q[2];
                k_d[2]     = k_q[3];
                k_d[3]     = k_new;
                round_d    = round_q + 5'd1;
            end
            default: ;
        endcase
    end

    assign bus.count    = count_q;
    assign bus.rk       = rk_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
endmodule
